// File: rtl/stdp_pkg.sv
// stdp_pkg: default parameters and saturating arithmetic for the STDP LIF core
package stdp_pkg;
   localparam int N_SYN_D = 4;
   localparam int W_WIDTH_D = 8;
   localparam int V_WIDTH_D = 12;
   localparam int THRESH_D = 200;
   localparam int LEAK_SHIFT_D = 3;
   localparam int TR_WIDTH_D = 4;
   localparam int TR_MAX_D = 8;
   localparam int A_PLUS_D = 4;
   localparam int A_MINUS_D = 2;
   localparam int REFRAC_D = 2;
   localparam int W_INIT_D = 32;
   function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b, input logic [31:0] max);
      logic [32:0] s;
      s = {1'b0, a} + {1'b0, b};
      return (s > {1'b0, max}) ? max : s[31:0];
   endfunction
   function automatic logic [31:0] sat_sub(input logic [31:0] a, input logic [31:0] b);
      return (a > b) ? a - b : '0;
   endfunction
endpackage

// File: rtl/stdp_lif_core_if.sv
// stdp_lif_core_if: stimulus, learning control and weight access bundle of the neuron core
interface stdp_lif_core_if #(
   parameter int N_SYN = 4,
   parameter int W_WIDTH = 8,
   parameter int V_WIDTH = 12
);
   localparam int AW = N_SYN > 1 ? $clog2(N_SYN) : 1;
   logic               tick;
   logic [N_SYN-1:0]   pre_spike;
   logic               learn_en;
   logic               wr_en;
   logic [AW-1:0]      wr_addr;
   logic [W_WIDTH-1:0] wr_data;
   logic [AW-1:0]      rd_addr;
   logic [W_WIDTH-1:0] rd_data;
   logic               post_spike;
   logic [V_WIDTH-1:0] v_mem;
   logic               refrac;
   modport master (
      output tick, pre_spike, learn_en, wr_en, wr_addr, wr_data, rd_addr,
      input  rd_data, post_spike, v_mem, refrac
   );
   modport slave (
      input  tick, pre_spike, learn_en, wr_en, wr_addr, wr_data, rd_addr,
      output rd_data, post_spike, v_mem, refrac
   );
endinterface

// File: rtl/stdp_synapse.sv
// stdp_synapse: one plastic synapse holding its weight and presynaptic trace
module stdp_synapse
   import stdp_pkg::*;
#(
   parameter int W_WIDTH = W_WIDTH_D,
   parameter int TR_WIDTH = TR_WIDTH_D,
   parameter int TR_MAX = TR_MAX_D,
   parameter int A_PLUS = A_PLUS_D,
   parameter int A_MINUS = A_MINUS_D,
   parameter int W_INIT = W_INIT_D
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               tick_i,
   input  logic               learn_en_i,
   input  logic               pre_i,
   input  logic               fire_i,
   input  logic               post_tr_nz_i,
   input  logic               wr_i,
   input  logic [W_WIDTH-1:0] wr_data_i,
   output logic [W_WIDTH-1:0] w_o
);
   localparam logic [31:0] W_MAX = 32'((64'd1 << W_WIDTH) - 64'd1);
   logic [W_WIDTH-1:0]  w_q, w_d;
   logic [TR_WIDTH-1:0] tr_q, tr_d;
   logic                ltp, ltd;
   always_comb begin
      ltp = tick_i && learn_en_i && fire_i && (tr_q != '0 || pre_i);
      ltd = tick_i && learn_en_i && pre_i && post_tr_nz_i && !fire_i;
      tr_d = !tick_i ? tr_q : pre_i ? TR_WIDTH'(TR_MAX) : (tr_q != '0) ? tr_q - TR_WIDTH'(1) : tr_q;
      // a host write wins over learning in the same cycle
      w_d = wr_i ? wr_data_i
          : ltp ? W_WIDTH'(sat_add(32'(w_q), 32'(A_PLUS), W_MAX))
          : ltd ? W_WIDTH'(sat_sub(32'(w_q), 32'(A_MINUS)))
          : w_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         w_q <= W_WIDTH'(W_INIT);
         tr_q <= '0;
      end else begin
         w_q <= w_d;
         tr_q <= tr_d;
      end
   end
   assign w_o = w_q;
endmodule

// File: rtl/stdp_lif_core.sv
// stdp_lif_core: leaky integrate-and-fire neuron with N_SYN pair-based STDP synapses
module stdp_lif_core
   import stdp_pkg::*;
#(
   parameter int N_SYN = N_SYN_D,
   parameter int W_WIDTH = W_WIDTH_D,
   parameter int V_WIDTH = V_WIDTH_D,
   parameter int THRESH = THRESH_D,
   parameter int LEAK_SHIFT = LEAK_SHIFT_D,
   parameter int TR_WIDTH = TR_WIDTH_D,
   parameter int TR_MAX = TR_MAX_D,
   parameter int A_PLUS = A_PLUS_D,
   parameter int A_MINUS = A_MINUS_D,
   parameter int REFRAC = REFRAC_D,
   parameter int W_INIT = W_INIT_D
) (
   input logic              clk,
   input logic              rst,
   stdp_lif_core_if.slave   bus
);
   localparam int AW = N_SYN > 1 ? $clog2(N_SYN) : 1;
   localparam int IW = W_WIDTH + $clog2(N_SYN);
   localparam int RW = $clog2(REFRAC + 2);
   localparam logic [31:0] V_MAX = 32'((64'd1 << V_WIDTH) - 64'd1);
   logic [W_WIDTH-1:0]  w [N_SYN];
   logic [IW-1:0]       isum;
   logic [V_WIDTH-1:0]  v_q, v_d, leaked;
   logic [31:0]         vn;
   logic                fire;
   logic [RW-1:0]       rf_q, rf_d;
   logic [TR_WIDTH-1:0] pt_q, pt_d;
   logic                post_q;
   logic [W_WIDTH-1:0]  rd_q;
   for (genvar i = 0; i < N_SYN; i++) begin : g_syn
      stdp_synapse #(
         .W_WIDTH(W_WIDTH), .TR_WIDTH(TR_WIDTH), .TR_MAX(TR_MAX),
         .A_PLUS(A_PLUS), .A_MINUS(A_MINUS), .W_INIT(W_INIT)
      ) u_syn (
         .clk(clk), .rst(rst), .tick_i(bus.tick), .learn_en_i(bus.learn_en),
         .pre_i(bus.pre_spike[i]), .fire_i(fire), .post_tr_nz_i(pt_q != '0),
         .wr_i(bus.wr_en && bus.wr_addr == AW'(i)), .wr_data_i(bus.wr_data), .w_o(w[i])
      );
   end
   always_comb begin
      isum = '0;
      for (int k = 0; k < N_SYN; k++) isum = isum + (bus.pre_spike[k] ? IW'(w[k]) : '0);
      leaked = v_q - (v_q >> LEAK_SHIFT);
      vn = sat_add(32'(leaked), 32'(isum), V_MAX);
      fire = bus.tick && rf_q == '0 && vn >= 32'(THRESH);
      // refractory ticks pin the membrane at 0 and ignore input
      v_d = !bus.tick ? v_q : (fire || rf_q != '0) ? '0 : V_WIDTH'(vn);
      rf_d = !bus.tick ? rf_q : fire ? RW'(REFRAC) : (rf_q != '0) ? rf_q - RW'(1) : rf_q;
      pt_d = !bus.tick ? pt_q : fire ? TR_WIDTH'(TR_MAX) : (pt_q != '0) ? pt_q - TR_WIDTH'(1) : pt_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         v_q <= '0;
         rf_q <= '0;
         pt_q <= '0;
         post_q <= 1'b0;
         rd_q <= '0;
      end else begin
         v_q <= v_d;
         rf_q <= rf_d;
         pt_q <= pt_d;
         post_q <= fire;
         rd_q <= w[bus.rd_addr];
      end
   end
   assign bus.v_mem = v_q;
   assign bus.post_spike = post_q;
   assign bus.refrac = rf_q != '0;
   assign bus.rd_data = rd_q;
endmodule
